resp_checker: RTL and testbench

Synthesizable response checker that forms the receiving end of the stimulus/compare flow used by the per-testcase post-route benches. It takes a golden-model output and a post-route netlist output, aligns them for a fixed netlist latency, and compares a programmed number of vectors. It counts mismatches and reports pass/fail, so the compare step can run on-fabric or be reused inside benches.

---
 rtl/resp_checker_pkg.sv | 13 +
 rtl/resp_align_pipe.sv | 48 ++++
 rtl/resp_checker.sv | 131 +++++++++++++
 tb/tb_resp_checker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_checker_pkg.sv
// Shared definitions for the response checker: FSM state encoding and the
// largest supported netlist latency.
package resp_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NET_LAT_MAX = 15;

endpackage

// File: rtl/resp_align_pipe.sv
// Valid+data delay line that lines the golden stream up with the netlist
// output. A depth of 0 is a pure combinational pass-through.
module resp_align_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = clk ^ rst;
            assign out_valid     = in_valid;
            assign out_data      = in_data;
        end else begin : g_pipe
            logic             valid_sr [DEPTH];
            logic [WIDTH-1:0] data_sr  [DEPTH];

            // NOTE: the data stages are reset along with the valid bits so a flushed pipe holds no stale samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_sr[i] <= 1'b0;
                        data_sr[i]  <= '0;
                    end
                end else begin
                    // NOTE: non-blocking updates let every stage shift from its pre-edge neighbour.
                    valid_sr[0] <= in_valid;
                    data_sr[0]  <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_sr[i] <= valid_sr[i-1];
                        data_sr[i]  <= data_sr[i-1];
                    end
                end
            end

            assign out_valid = valid_sr[DEPTH-1];
            assign out_data  = data_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/resp_checker.sv
// Response checker: aligns golden and netlist outputs, counts compares and
// mismatches over a programmed run. Define RESP_CHECKER_FIRST_FAIL_EN to add
// first-mismatch capture outputs (ff_valid, ff_idx, ff_gold, ff_net).
module resp_checker
    import resp_checker_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int CNT_W   = 16,
    parameter int NET_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] netlist,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`ifdef RESP_CHECKER_FIRST_FAIL_EN
    ,
    output logic             ff_valid,
    output logic [CNT_W-1:0] ff_idx,
    output logic [WIDTH-1:0] ff_gold,
    output logic [WIDTH-1:0] ff_net
`endif
);

    localparam int LAT = (NET_LAT > NET_LAT_MAX) ? NET_LAT_MAX : NET_LAT;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] num_lat;
    logic             dly_valid;
    logic [WIDTH-1:0] dly_gold;
    logic             restart;
    logic             cmp_en;
    logic             miss;

    resp_align_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (LAT)
    ) u_align (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vec_valid),
        .in_data   (golden),
        .out_valid (dly_valid),
        .out_data  (dly_gold)
    );

    assign restart = start && (state != RUN);
    // Once the programmed count is reached, late pipeline samples are dropped.
    assign cmp_en  = (state == RUN) && dly_valid && (vec_cnt != num_lat);
    assign miss    = (dly_gold != netlist);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting to the current state first keeps this block free of latches.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (vec_cnt == num_lat) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            pass <= done_nxt && (mismatch_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat      <= '0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (restart) begin
            num_lat      <= num_vec;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (cmp_en) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (miss && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

`ifdef RESP_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            ff_valid <= 1'b0;
            ff_idx   <= '0;
            ff_gold  <= '0;
            ff_net   <= '0;
        end else if (cmp_en && miss && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_idx   <= vec_cnt;
            ff_gold  <= dly_gold;
            ff_net   <= netlist;
        end
    end
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker: three instances cover zero latency,
// a three-cycle latency and a narrow saturating counter.
module tb_resp_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u_main: WIDTH 8, CNT_W 16, NET_LAT 0
    logic        m_start, m_valid, m_busy, m_done, m_pass;
    logic [15:0] m_num, m_vec, m_mis;
    logic [7:0]  m_gold, m_net;
    // u_lat: WIDTH 8, CNT_W 16, NET_LAT 3
    logic        l_start, l_valid, l_busy, l_done, l_pass;
    logic [15:0] l_num, l_vec, l_mis;
    logic [7:0]  l_gold, l_net;
    // u_sat: WIDTH 8, CNT_W 4, NET_LAT 0
    logic        s_start, s_valid, s_busy, s_done, s_pass;
    logic [3:0]  s_num, s_vec, s_mis;
    logic [7:0]  s_gold, s_net;
`ifdef RESP_CHECKER_FIRST_FAIL_EN
    logic        m_ffv, l_ffv, s_ffv;
    logic [15:0] m_ffi, l_ffi;
    logic [3:0]  s_ffi;
    logic [7:0]  m_ffg, m_ffn, l_ffg, l_ffn, s_ffg, s_ffn;
`endif

    resp_checker #(.WIDTH(8), .CNT_W(16), .NET_LAT(0)) u_main (
        .clk(clk), .rst(rst), .start(m_start), .num_vec(m_num),
        .vec_valid(m_valid), .golden(m_gold), .netlist(m_net),
        .busy(m_busy), .done(m_done), .pass(m_pass),
        .vec_cnt(m_vec), .mismatch_cnt(m_mis)
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(m_ffv), .ff_idx(m_ffi), .ff_gold(m_ffg), .ff_net(m_ffn)
`endif
    );

    resp_checker #(.WIDTH(8), .CNT_W(16), .NET_LAT(3)) u_lat (
        .clk(clk), .rst(rst), .start(l_start), .num_vec(l_num),
        .vec_valid(l_valid), .golden(l_gold), .netlist(l_net),
        .busy(l_busy), .done(l_done), .pass(l_pass),
        .vec_cnt(l_vec), .mismatch_cnt(l_mis)
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(l_ffv), .ff_idx(l_ffi), .ff_gold(l_ffg), .ff_net(l_ffn)
`endif
    );

    resp_checker #(.WIDTH(8), .CNT_W(4), .NET_LAT(0)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .num_vec(s_num),
        .vec_valid(s_valid), .golden(s_gold), .netlist(s_net),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_cnt(s_vec), .mismatch_cnt(s_mis)
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(s_ffv), .ff_idx(s_ffi), .ff_gold(s_ffg), .ff_net(s_ffn)
`endif
    );

    typedef struct {
        int         due;
        logic [7:0] gold;
        logic [7:0] net;
    } sb_item_t;

    sb_item_t mq[$];
    int       me_vec, me_mis, me_num;
    bit       me_run;
    logic [7:0] g6;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic main_start(input int n);
        m_start = 1'b1;
        m_num   = 16'(n);
        me_run  = 1'b1;
        me_num  = n;
        me_vec  = 0;
        me_mis  = 0;
        mq.delete();
        step();
        m_start = 1'b0;
    endtask

    // Drive one vector on u_main; counted vectors go through the scoreboard.
    task automatic main_vec(input logic [7:0] g, input logic [7:0] n, input string tag);
        sb_item_t e;
        m_valid = 1'b1;
        m_gold  = g;
        m_net   = n;
        if (me_run && me_vec < me_num) mq.push_back('{0, g, n});
        step();
        m_valid = 1'b0;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            me_vec++;
            if (e.gold !== e.net) me_mis++;
        end
        check({tag, "_vec"}, 32'(m_vec), 32'(me_vec));
        check({tag, "_mis"}, 32'(m_mis), 32'(me_mis));
    endtask

    task automatic main_finish(input string tag);
        step();
        me_run = 1'b0;
        check({tag, "_done"}, 32'(m_done), 32'd1);
        check({tag, "_busy"}, 32'(m_busy), 32'd0);
        check({tag, "_vec_end"}, 32'(m_vec), 32'(me_vec));
        check({tag, "_mis_end"}, 32'(m_mis), 32'(me_mis));
        check({tag, "_pass"}, 32'(m_pass), (me_mis == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_lat(input int d, input string tag);
        sb_item_t   lq[$];
        sb_item_t   e;
        logic [7:0] hist [600];
        int         ev = 0;
        int         em = 0;
        l_start = 1'b1;
        l_num   = 16'd500;
        step();
        l_start = 1'b0;
        for (int c = 0; c < 503; c++) begin
            if (c < 500) begin
                l_valid = 1'b1;
                l_gold  = 8'($urandom);
                lq.push_back('{c + 3, l_gold, 8'h00});
            end else begin
                l_valid = 1'b0;
                l_gold  = 8'h00;
            end
            hist[c] = l_gold;
            l_net   = (c >= d) ? hist[c - d] : 8'h00;
            step();
            if (lq.size() > 0 && lq[0].due == c) begin
                e = lq.pop_front();
                ev++;
                if (e.gold !== l_net) em++;
            end
            check({tag, "_vec"}, 32'(l_vec), 32'(ev));
            check({tag, "_mis"}, 32'(l_mis), 32'(em));
        end
        l_valid = 1'b0;
        step();
        check({tag, "_done"}, 32'(l_done), 32'd1);
        check({tag, "_vec_end"}, 32'(l_vec), 32'd500);
        check({tag, "_pass"}, 32'(l_pass), (em == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sv;
        int sm;
        rst = 1'b1;
        m_start = 1'b0; m_num = '0; m_valid = 1'b0; m_gold = '0; m_net = '0;
        l_start = 1'b0; l_num = '0; l_valid = 1'b0; l_gold = '0; l_net = '0;
        s_start = 1'b0; s_num = '0; s_valid = 1'b0; s_gold = '0; s_net = '0;
        me_run = 1'b0; me_vec = 0; me_mis = 0; me_num = 0;
        repeat (3) step();
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_pass", 32'(m_pass), 32'd0);
        check("rst_vec", 32'(m_vec), 32'd0);
        check("rst_mis", 32'(m_mis), 32'd0);
        check("rst_lat_busy", 32'(l_busy), 32'd0);
        check("rst_sat_busy", 32'(s_busy), 32'd0);
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        check("rst_ffv", 32'(m_ffv), 32'd0);
        check("rst_lat_ffv", 32'(l_ffv | (|l_ffi) | (|l_ffg) | (|l_ffn)), 32'd0);
        check("rst_sat_ffv", 32'(s_ffv | (|s_ffi) | (|s_ffg) | (|s_ffn)), 32'd0);
`endif
        rst = 1'b0;
        step();

        // AND truth table, netlist matches golden
        main_start(4);
        check("and_start_busy", 32'(m_busy), 32'd1);
        check("and_start_vec", 32'(m_vec), 32'd0);
        for (int i = 0; i < 4; i++) begin
            main_vec({7'b0, i[1] & i[0]}, {7'b0, i[1] & i[0]}, "and");
        end
        check("and_done_early", 32'(m_done), 32'd0);
        main_finish("and");

        // Compare event while in DONE is discarded and done holds
        main_vec(8'h01, 8'h00, "done_disc");
        check("done_hold", 32'(m_done), 32'd1);

        // Restart coinciding with a compare event in DONE: counters clear
        m_valid = 1'b1; m_gold = 8'h0f; m_net = 8'hf0;
        main_start(10);
        m_valid = 1'b0;
        check("restart_vec", 32'(m_vec), 32'd0);
        check("restart_mis", 32'(m_mis), 32'd0);
        check("restart_busy", 32'(m_busy), 32'd1);

        // Single inverted vector at index 6
        g6 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (i == 6) g6 = g;
            main_vec(g, (i == 6) ? ~g : g, "idx6");
        end
        main_finish("idx6");
        check("idx6_one_mis", 32'(m_mis), 32'd1);
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        check("ff_valid", 32'(m_ffv), 32'd1);
        check("ff_idx", 32'(m_ffi), 32'd6);
        check("ff_gold", 32'(m_ffg), 32'(g6));
        check("ff_net", 32'(m_ffn), 32'(~g6));
`endif

        // start during RUN is ignored
        main_start(4);
        main_vec(8'h01, 8'h01, "runst");
        main_vec(8'h02, 8'h03, "runst");
        m_start = 1'b1; m_num = 16'd1;
        main_vec(8'h04, 8'h04, "runst");
        m_start = 1'b0;
        check("runst_busy", 32'(m_busy), 32'd1);
        main_vec(8'h05, 8'h05, "runst");
        main_finish("runst");
        check("runst_vec4", 32'(m_vec), 32'd4);

        // num_vec = 0
        main_start(0);
        check("zero_busy", 32'(m_busy), 32'd1);
        check("zero_done_early", 32'(m_done), 32'd0);
        main_finish("zero");
        check("zero_pass", 32'(m_pass), 32'd1);

        // Reset mid-run aborts without done, then a clean full run
        main_start(10);
        for (int i = 0; i < 5; i++) main_vec(8'(i), 8'(i + 1), "abort");
        rst = 1'b1;
        step();
        rst = 1'b0;
        me_run = 1'b0; me_vec = 0; me_mis = 0;
        mq.delete();
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_pass", 32'(m_pass), 32'd0);
        check("abort_vec", 32'(m_vec), 32'd0);
        check("abort_mis", 32'(m_mis), 32'd0);
`ifdef RESP_CHECKER_FIRST_FAIL_EN
        check("abort_ffv", 32'(m_ffv), 32'd0);
`endif
        main_start(10);
        for (int i = 0; i < 10; i++) main_vec(8'(i * 7), 8'(i * 7), "clean");
        main_finish("clean");
        check("clean_pass", 32'(m_pass), 32'd1);

        // NET_LAT = 3: aligned netlist passes, misaligned netlist fails
        run_lat(3, "lat3");
        check("lat3_pass", 32'(l_pass), 32'd1);
        check("lat3_mis0", 32'(l_mis), 32'd0);
        run_lat(2, "lat2");
        check("lat2_mis_nz", 32'(l_mis != 16'd0), 32'd1);
        check("lat2_fail", 32'(l_pass), 32'd0);

        // CNT_W = 4: every vector mismatches, count stops at 15
        s_start = 1'b1; s_num = 4'd15;
        step();
        s_start = 1'b0;
        sv = 0;
        sm = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_gold  = 8'($urandom);
            s_net   = ~s_gold;
            step();
            if (sv < 15) begin
                sv++;
                sm = (sm == 15) ? 15 : sm + 1;
            end
            check("sat_vec", 32'(s_vec), 32'(sv));
            check("sat_mis", 32'(s_mis), 32'(sm));
        end
        s_valid = 1'b0;
        step();
        check("sat_done", 32'(s_done), 32'd1);
        check("sat_busy", 32'(s_busy), 32'd0);
        check("sat_mis15", 32'(s_mis), 32'd15);
        check("sat_vec15", 32'(s_vec), 32'd15);
        check("sat_pass", 32'(s_pass), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
